// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and defaults for the IF/ID / ID/EX pipeline sequencer.
//   pipe_ctrl_state_t : sequencer state (RUN, MUL_WAIT, REDIRECT)
//   *_DEF             : default parameter values used by pipe_hazard_ctrl
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MUL_WAIT = 2'd1,
        REDIRECT = 2'd2
    } pipe_ctrl_state_t;

    localparam int unsigned REG_AW_DEF      = 5;
    localparam int unsigned MUL_LATENCY_DEF = 4;
    localparam int unsigned CNT_W_DEF       = 16;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare between the instruction in ID and a load in EX.
//   id_rs1/id_rs2      : source registers of the ID instruction
//   id_uses_rs1/rs2    : ID instruction actually reads that source
//   ex_is_load, ex_rd  : EX instruction is a load writing ex_rd
//   load_use_c         : ID must wait one cycle for the load data
module hazard_detect
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_rd,
    output logic              load_use_c
);

    logic rs1_hit;
    logic rs2_hit;

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    always_comb begin
        rs1_hit    = id_uses_rs1 && (id_rs1 == ex_rd);
        rs2_hit    = id_uses_rs2 && (id_rs2 == ex_rd);
        load_use_c = ex_is_load && (ex_rd != '0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Sequencer for the IF/ID and ID/EX pipeline registers.
// Decides per cycle whether PC/IF-ID advance, hold or flush, and whether
// ID/EX takes a bubble (load-use, taken branch, imem wait, multi-cycle MUL).
//   clk, resetn        : clock, async active-low reset
//   imem_ack           : instruction word valid this cycle
//   id_* / ex_*        : hazard inputs from the ID and EX stages
//   imem_req           : fetch request
//   pc_en, if_id_en    : PC / IF-ID update enables
//   if_id_flush        : load NOP into IF/ID (overrides if_id_en)
//   id_ex_bubble       : load NOP into ID/EX
//   ctrl_state         : current sequencer state (debug)
//   stall_cnt          : saturating count of cycles with pc_en low
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW      = REG_AW_DEF,
    parameter int unsigned MUL_LATENCY = MUL_LATENCY_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              imem_ack,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              id_is_mul,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_br_taken,
    output logic              imem_req,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic [1:0]        ctrl_state,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Holds values up to MUL_LATENCY-1
    localparam int unsigned MUL_CW = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY) : 1;

    pipe_ctrl_state_t  state_q,     state_d;
    logic [MUL_CW-1:0] mul_cnt_q,   mul_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              load_use;

    hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_is_load  (ex_is_load),
        .ex_rd       (ex_rd),
        .load_use_c  (load_use)
    );

    // State and counter registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= RUN;
            mul_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mul_cnt_q   <= mul_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next state, MUL occupancy countdown and stall counter
    always_comb begin
        state_d     = state_q;
        mul_cnt_d   = mul_cnt_q;
        stall_cnt_d = stall_cnt_q;
        unique case (state_q)
            RUN: begin
                if (ex_br_taken) begin
                    // Without ack the old fetch is still outstanding and must be dropped
                    if (!imem_ack) state_d = REDIRECT;
                end else if (load_use || !imem_ack) begin
                    state_d = RUN;
                end else if (id_is_mul) begin
                    mul_cnt_d = MUL_CW'(MUL_LATENCY - 1);
                    state_d   = MUL_WAIT;
                end
            end
            MUL_WAIT: begin
                mul_cnt_d = mul_cnt_q - MUL_CW'(1);
                if (mul_cnt_q == MUL_CW'(1)) state_d = RUN;
            end
            REDIRECT: begin
                if (imem_ack) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        if (!pc_en && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    // Pipe-register controls; reset forces a bubble and holds everything else
    always_comb begin
        imem_req     = 1'b0;
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b1;
        if (resetn) begin
            unique case (state_q)
                RUN: begin
                    imem_req = 1'b1;
                    if (ex_br_taken) begin
                        pc_en       = 1'b1;
                        if_id_flush = 1'b1;
                    end else if (load_use) begin
                        id_ex_bubble = 1'b1;
                    end else if (!imem_ack) begin
                        // Current ID instruction still moves on; ID refills with a NOP
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b0;
                    end else begin
                        pc_en        = 1'b1;
                        if_id_en     = 1'b1;
                        id_ex_bubble = 1'b0;
                    end
                end
                MUL_WAIT: begin
                    id_ex_bubble = 1'b1;
                end
                REDIRECT: begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end
                default: begin
                    id_ex_bubble = 1'b1;
                end
            endcase
        end
    end

    assign ctrl_state = state_q;
    assign stall_cnt  = stall_cnt_q;

endmodule
